laplacian_border_packer: RTL and testbench
==========================================

# laplacian_border_packer

Output-side companion to the `laplacian` core. It accepts the core's interior result stream (`data_o` qualified by `sonuc_done`), converts each signed 9-bit result to an 8-bit pixel, and adds a zero border. It emits a full IMG_W×IMG_H raster frame on a valid/ready stream toward frame storage or the file/display writer. It replaces software post-processing that pads the 318×238 interior into a 320×240 frame.

## Interface
- `IMG_W`, 320: frame width in pixels, ≥3.
- `IMG_H`, 240: frame height in pixels, ≥3.
- `ABS_MODE`, 0: 0 = clamp negative results to 0; 1 = absolute value, saturated to 255.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  begin a frame; sampled only in IDLE.
- `in_valid_i`  in  1  interior result valid; connects to `sonuc_done`.
- `in_data_i`  in  9  signed interior result; connects to `data_o`.
- `in_ready_o`  out  1  input accepted this cycle when high together with `in_valid_i`.
- `out_valid_o`  out  1  output pixel valid.
- `out_data_o`  out  8  output pixel.
- `out_ready_i`  in  1  sink accepts the pixel.
- `out_last_o`  out  1  high with the last pixel of each row (x = IMG_W−1).
- `out_frame_end_o`  out  1  high with the final pixel of the frame.
- `busy_o`  out  1  high from the cycle after start until frame_done.
- `frame_done_o`  out  1  one-cycle pulse after the final output handshake.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on `start_i`.
  - RUN→DRAIN after loading pixel (IMG_W−1, IMG_H−1).
  - DRAIN→DONE on the final output handshake.
  - DONE→IDLE unconditionally; `frame_done_o` = 1 in DONE.
- **Position counters:** x (0..IMG_W−1) and y (0..IMG_H−1) give the next pixel to load. x wraps to 0 and increments y. Both counters are cleared on entering RUN.
- **Border pixel:** any pixel with x==0, x==IMG_W−1, y==0 or y==IMG_H−1. It loads value 0 and consumes no input.
- **Interior pixel:** loads the converted `in_data_i`. It requires `in_valid_i`; while `in_valid_i` is low, nothing loads and the position holds.
- **Load condition (RUN only):** `(!out_valid_o || out_ready_i) && (border || in_valid_i)`.
- **Input ready:** `in_ready_o = RUN && interior && (!out_valid_o || out_ready_i)`. Input presented during border positions, IDLE, DRAIN or DONE is not accepted and remains pending.
- **Output register:** single stage. `out_data_o`, `out_last_o` and `out_frame_end_o` are registered with the pixel and stay stable while `out_valid_o && !out_ready_i`.
- **Conversion, ABS_MODE=0:** negative → 0; 0..255 passes through.
- **Conversion, ABS_MODE=1:** |v|, with −256 → 255.
- **Input count:** exactly (IMG_W−2)(IMG_H−2) inputs per frame, which is 75684 at the defaults.
- **Output count:** exactly IMG_W·IMG_H outputs per frame, which is 76800 at the defaults.
- **`start_i` while busy:** ignored.
- **Reset, at any time including mid-frame:** state = IDLE; x = y = 0; all outputs 0; `in_ready_o` = 0. The partially output frame is abandoned, and the next frame begins only on a new `start_i`.

## Timing
- **Start latency:** `start_i` high at edge N puts the state in RUN after N. Pixel (0,0) loads at edge N+1, so `out_valid_o` is high after edge N+1.
- **Throughput:** one pixel per cycle when `out_ready_i` = 1 and input is available at interior positions. No bubble occurs at row wrap or at border/interior transitions.
- **Input-to-output latency:** an interior input accepted at edge K appears on `out_data_o` after edge K.
- **Unstalled frame:** with ready and input always available, a frame takes IMG_W·IMG_H output cycles. `frame_done_o` pulses exactly one cycle after the final handshake.
- **`out_valid_o` deassertion:** it drops only when the register drains while the next position is interior and `in_valid_i` is low.
- **Same-cycle drain and reload:** when drain and load occur in the same cycle, `out_valid_o` stays high.

## Test plan
- **Small frame, clamp mode:** IMG_W=5, IMG_H=4, ABS_MODE=0, ready=1, inputs −5, 0, 7, 255, −256, 100 held valid → rows 0,0,0,0,0 / 0,0,0,7,0 / 0,255,0,100,0 / 0,0,0,0,0. `out_last_o` is high on 4 pixels, `out_frame_end_o` on the 20th, `frame_done_o` pulses once, and 6 inputs are accepted.
- **ABS mode:** ABS_MODE=1, same inputs → interior 5, 0, 7, 255, 255, 100.
- **Backpressure:** `out_ready_i` toggles randomly → data and flags are stable while stalled, there are no drops or duplicates, and the sequence is identical to the first test.
- **Input starvation:** `in_valid_i` is low for 10 cycles at interior (1,2) → `out_valid_o` drops after the border pixel drains, `in_ready_o` stays high, and output resumes with the correct value.
- **Reset mid-frame:** `rst_i` asserted at pixel 9 → outputs are 0 immediately, asynchronously. A new `start_i` yields a correct full frame from (0,0).
- **Default size:** 320×240, ready=1, ramp input → 76800 outputs, 75684 inputs, 240 `out_last_o` pulses, `frame_done_o` 76801 cycles after the first valid. `start_i` pulsed mid-frame is ignored.

Source files
------------

// File: rtl/laplacian_border_packer_if.sv
// Stream bundle for the border packer: interior results in, bordered 8-bit raster out.
// The slave modport is the packer side; the master modport is the core/sink side.
interface laplacian_border_packer_if;
  logic       in_valid_i;
  logic [8:0] in_data_i;
  logic       in_ready_o;
  logic       out_valid_o;
  logic [7:0] out_data_o;
  logic       out_ready_i;
  logic       out_last_o;
  logic       out_frame_end_o;

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_last_o, out_frame_end_o
  );

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_last_o, out_frame_end_o
  );
endinterface

// File: rtl/laplacian_border_packer.sv
// Wraps the laplacian interior result stream in a zero border and emits a full
// IMG_W x IMG_H raster of 8-bit pixels through a single-stage output register.
module laplacian_border_packer #(
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240,
  parameter int ABS_MODE = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  laplacian_border_packer_if.slave  io,
  output logic                      busy_o,
  output logic                      frame_done_o
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_out_valid;
  logic [7:0]    r_out_data;
  logic          r_out_last;
  logic          r_out_frame_end;
  logic          r_busy;
  logic          r_frame_done;

  logic          w_x_last;
  logic          w_y_last;
  logic          w_border;
  logic          w_room;
  logic          w_run;
  logic          w_load;
  logic [7:0]    w_pix;

  // Signed 9-bit result to 8-bit pixel; -256 has magnitude 256 and saturates.
  function automatic logic [7:0] f_convert(input logic [8:0] v);
    logic [8:0] mag;
    logic [7:0] res;
    if (ABS_MODE != 0) begin
      mag = v[8] ? (~v + 9'd1) : v;
      res = mag[8] ? 8'hFF : mag[7:0];
    end else begin
      mag = v;
      res = v[8] ? 8'h00 : mag[7:0];
    end
    return res;
  endfunction

  // Position classification and the load decision for the current cycle.
  always_comb begin
    w_x_last = (r_x == X_LAST);
    w_y_last = (r_y == Y_LAST);
    w_border = (r_x == {XW{1'b0}}) || w_x_last || (r_y == {YW{1'b0}}) || w_y_last;
    w_room   = !r_out_valid || io.out_ready_i;
    w_run    = (r_state == S_RUN);
    w_load   = w_run && w_room && (w_border || io.in_valid_i);
    w_pix    = w_border ? 8'h00 : f_convert(io.in_data_i);
  end

  assign io.in_ready_o      = w_run && !w_border && w_room;
  assign io.out_valid_o     = r_out_valid;
  assign io.out_data_o      = r_out_data;
  assign io.out_last_o      = r_out_last;
  assign io.out_frame_end_o = r_out_frame_end;
  assign busy_o             = r_busy;
  assign frame_done_o       = r_frame_done;

  // Frame FSM, raster position counters and the output pixel register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state         <= S_IDLE;
      r_x             <= {XW{1'b0}};
      r_y             <= {YW{1'b0}};
      r_out_valid     <= 1'b0;
      r_out_data      <= 8'h00;
      r_out_last      <= 1'b0;
      r_out_frame_end <= 1'b0;
      r_busy          <= 1'b0;
      r_frame_done    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_RUN;
            r_x     <= {XW{1'b0}};
            r_y     <= {YW{1'b0}};
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_load) begin
            r_out_valid     <= 1'b1;
            r_out_data      <= w_pix;
            r_out_last      <= w_x_last;
            r_out_frame_end <= w_x_last && w_y_last;
            if (w_x_last) begin
              r_x <= {XW{1'b0}};
              if (w_y_last) begin
                r_y     <= {YW{1'b0}};
                r_state <= S_DRAIN;
              end else begin
                r_y <= r_y + YW'(1);
              end
            end else begin
              r_x <= r_x + XW'(1);
            end
          end else if (io.out_ready_i) begin
            // Register drained while starved at an interior position.
            r_out_valid     <= 1'b0;
            r_out_last      <= 1'b0;
            r_out_frame_end <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (r_out_valid && io.out_ready_i) begin
            r_out_valid     <= 1'b0;
            r_out_last      <= 1'b0;
            r_out_frame_end <= 1'b0;
            r_busy          <= 1'b0;
            r_frame_done    <= 1'b1;
            r_state         <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_laplacian_border_packer.sv
// Bench: two 5x4 packers (clamp and abs mode) driven in lockstep plus one 320x240 packer,
// each checked against a raster model built from the input list.
module tb_laplacian_border_packer;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       f;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [2:0] start_v     = 3'b000;
  logic [2:0] in_valid_v  = 3'b000;
  logic [2:0] out_ready_v = 3'b111;
  logic [8:0] in_data_v [3];
  logic [2:0] o_valid, o_last, o_fe, o_inrdy, o_busy, o_done;
  logic [7:0] o_data [3];

  pix_t       exp_q [3][$];
  int         cap_q [3][$];
  logic [8:0] src   [3][$];
  int  src_idx[3], hold[3], starve_at[3];
  bit  feed_en[3], rnd_rdy[3], acc[3], seen_v[3];
  int  n_out[3], n_last[3], n_fe[3], n_done[3], n_in[3], n_vlow[3], vcyc[3], done_at[3];
  int  n_cmp = 0;
  int  n_bad = 0;

  int lit [2][20] = '{
    '{0,0,0,0,0, 0,0,0,7,0, 0,255,0,100,0, 0,0,0,0,0},
    '{0,0,0,0,0, 0,5,0,7,0, 0,255,255,100,0, 0,0,0,0,0}
  };
  int small_in [6] = '{-5, 0, 7, 255, -256, 100};

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    laplacian_border_packer_if bus ();
    assign bus.in_valid_i  = in_valid_v[g];
    assign bus.in_data_i   = in_data_v[g];
    assign bus.out_ready_i = out_ready_v[g];
    assign o_valid[g]      = bus.out_valid_o;
    assign o_data[g]       = bus.out_data_o;
    assign o_last[g]       = bus.out_last_o;
    assign o_fe[g]         = bus.out_frame_end_o;
    assign o_inrdy[g]      = bus.in_ready_o;
    laplacian_border_packer #(
      .IMG_W    (g == 2 ? 320 : 5),
      .IMG_H    (g == 2 ? 240 : 4),
      .ABS_MODE (g == 1 ? 1 : 0)
    ) u_dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start_v[g]),
      .io           (bus),
      .busy_o       (o_busy[g]),
      .frame_done_o (o_done[g])
    );
  end

  function automatic int fw(int g); return (g == 2) ? 320 : 5; endfunction
  function automatic int fh(int g); return (g == 2) ? 240 : 4; endfunction

  function automatic int conv(int v, int absm);
    int r = v;
    if (absm != 0 && r < 0) r = -r;
    if (r < 0) r = 0;
    if (r > 255) r = 255;
    return r;
  endfunction

  task automatic chk(string name, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Raster model: walk every position, border -> 0, interior -> next converted input.
  task automatic setup(int g, bit rnd, int starve);
    int   k = 0;
    pix_t p;
    exp_q[g].delete();
    cap_q[g].delete();
    for (int y = 0; y < fh(g); y++) begin
      for (int x = 0; x < fw(g); x++) begin
        p.l = (x == fw(g) - 1);
        p.f = (x == fw(g) - 1) && (y == fh(g) - 1);
        if (x == 0 || y == 0 || x == fw(g) - 1 || y == fh(g) - 1) begin
          p.d = 8'h00;
        end else begin
          p.d = 8'(conv(int'($signed(src[g][k])), (g == 1) ? 1 : 0));
          k++;
        end
        exp_q[g].push_back(p);
      end
    end
    src_idx[g] = 0; hold[g] = 0; starve_at[g] = starve; rnd_rdy[g] = rnd; acc[g] = 1'b0;
    n_out[g] = 0; n_last[g] = 0; n_fe[g] = 0; n_done[g] = 0; n_in[g] = 0; n_vlow[g] = 0;
    vcyc[g] = 0; seen_v[g] = 1'b0; done_at[g] = -1;
    feed_en[g] = 1'b1;
  endtask

  task automatic kick(logic [2:0] mask);
    @(posedge clk); #2;
    start_v = mask;
    @(posedge clk); #2;
    start_v = 3'b000;
  endtask

  // Compare on the falling edge, then drive the next cycle's inputs just after the rising edge.
  always begin
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      if (rst) begin
        acc[g] = 1'b0;
      end else begin
        acc[g] = in_valid_v[g] && o_inrdy[g];
        if (acc[g]) n_in[g]++;
        if (o_valid[g]) begin
          if (!seen_v[g]) begin seen_v[g] = 1'b1; vcyc[g] = 0; end
          if (exp_q[g].size() == 0) begin
            n_bad++;
            $display("FAIL extra_pixel: dut %0d valid with no pixel expected (t=%0t)", g, $time);
          end else begin
            chk("pix_data", int'(o_data[g]), int'(exp_q[g][0].d));
            chk("pix_last", int'(o_last[g]), int'(exp_q[g][0].l));
            chk("pix_fend", int'(o_fe[g]),   int'(exp_q[g][0].f));
          end
          if (out_ready_v[g]) begin
            cap_q[g].push_back(int'(o_data[g]));
            if (exp_q[g].size() != 0) void'(exp_q[g].pop_front());
            n_out[g]++;
            n_last[g] += int'(o_last[g]);
            n_fe[g]   += int'(o_fe[g]);
          end
        end
        if (seen_v[g]) vcyc[g]++;
        if (o_done[g]) begin n_done[g]++; done_at[g] = vcyc[g]; end
        if (hold[g] > 0 && !o_valid[g]) begin
          n_vlow[g]++;
          chk("starve_in_ready", int'(o_inrdy[g]), 1);
        end
      end
    end
    @(posedge clk); #1;
    for (int g = 0; g < 3; g++) begin
      if (acc[g]) src_idx[g]++;
      if (starve_at[g] >= 0 && src_idx[g] == starve_at[g]) begin
        hold[g] = 10;
        starve_at[g] = -1;
      end
      in_valid_v[g] = feed_en[g] && (src_idx[g] < src[g].size()) && (hold[g] == 0);
      in_data_v[g]  = (src_idx[g] < src[g].size()) ? src[g][src_idx[g]] : 9'h000;
      if (hold[g] > 0) hold[g]--;
      out_ready_v[g] = rnd_rdy[g] ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic wait_done(int g, int budget, string name);
    int c = 0;
    while (n_done[g] == 0 && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    if (n_done[g] == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: frame_done not seen after %0d cycles", name, budget);
    end
  endtask

  task automatic small_frame(bit rnd, int starve, bit do_rst);
    int c;
    for (int g = 0; g < 2; g++) begin
      src[g].delete();
      for (int i = 0; i < 6; i++) src[g].push_back(9'(small_in[i]));
      setup(g, rnd, starve);
    end
    kick(3'b011);
    if (do_rst) begin
      c = 0;
      while (n_out[0] < 9 && c < 200) begin @(negedge clk); #1; c++; end
      chk("reached_pixel_9", n_out[0], 9);
      rst = 1'b1;
      #1;
      chk("rst_out_valid", int'(o_valid[0]), 0);
      chk("rst_out_data",  int'(o_data[0]),  0);
      chk("rst_out_last",  int'(o_last[0]),  0);
      chk("rst_frame_end", int'(o_fe[0]),    0);
      chk("rst_in_ready",  int'(o_inrdy[0]), 0);
      chk("rst_busy",      int'(o_busy[0]),  0);
      @(negedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #2;
      for (int g = 0; g < 2; g++) setup(g, rnd, starve);
      kick(3'b011);
    end
    wait_done(0, 400, "small_done_clamp");
    wait_done(1, 400, "small_done_abs");
    repeat (4) @(posedge clk);
    #2;
    for (int g = 0; g < 2; g++) begin
      chk("small_out_count",  n_out[g],  20);
      chk("small_last_count", n_last[g], 4);
      chk("small_fend_count", n_fe[g],   1);
      chk("small_done_count", n_done[g], 1);
      chk("small_in_count",   n_in[g],   6);
      chk("small_left_over",  exp_q[g].size(), 0);
      for (int i = 0; i < 20 && i < cap_q[g].size(); i++) chk("small_literal", cap_q[g][i], lit[g][i]);
      if (!rnd && starve < 0) chk("small_done_at", done_at[g], 21);
      feed_en[g] = 1'b0;
    end
    if (starve >= 0) chk("starve_valid_dropped", int'(n_vlow[0] > 0), 1);
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      starve_at[g] = -1; feed_en[g] = 1'b0; in_data_v[g] = 9'h000; src_idx[g] = 0; hold[g] = 0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("reset_out_valid", int'(o_valid[g]), 0);
      chk("reset_in_ready",  int'(o_inrdy[g]), 0);
      chk("reset_busy",      int'(o_busy[g]),  0);
      chk("reset_done",      int'(o_done[g]),  0);
    end
    rst = 1'b0;
    @(posedge clk); #2;

    small_frame(1'b0, -1, 1'b0);
    small_frame(1'b1, -1, 1'b0);
    small_frame(1'b0,  3, 1'b0);
    small_frame(1'b0, -1, 1'b1);

    src[2].delete();
    for (int k = 0; k < 75684; k++) src[2].push_back(9'(k));
    setup(2, 1'b0, -1);
    kick(3'b100);
    for (int c = 0; c < 2000 && n_out[2] < 1000; c++) begin @(negedge clk); #1; end
    chk("big_busy_mid", int'(o_busy[2]), 1);
    kick(3'b100);
    wait_done(2, 80000, "big_done");
    repeat (3) @(posedge clk);
    #2;
    chk("big_out_count",  n_out[2],  76800);
    chk("big_in_count",   n_in[2],   75684);
    chk("big_last_count", n_last[2], 240);
    chk("big_fend_count", n_fe[2],   1);
    chk("big_done_count", n_done[2], 1);
    chk("big_done_at",    done_at[2], 76801);
    chk("big_left_over",  exp_q[2].size(), 0);
    chk("big_busy_end",   int'(o_busy[2]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
